// File: rtl/wshb_pixel_reader.sv
// wshb_pixel_reader: read-only Wishbone master streaming the frame buffer into a FIFO.
// Define WSHB_PIXEL_READER_BURST_EN to run incrementing bursts (cti 010/111).
module wshb_pixel_reader #(
   parameter int HDISP      = 800,
   parameter int VDISP      = 480,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        enable,
   output logic        wshb_cyc,
   output logic        wshb_stb,
   output logic        wshb_we,
   output logic [31:0] wshb_adr,
   output logic [3:0]  wshb_sel,
   output logic [2:0]  wshb_cti,
   output logic [1:0]  wshb_bte,
   input  logic [31:0] wshb_dat_sm,
   input  logic        wshb_ack,
   input  logic        wshb_err,
   input  logic        wshb_rty,
   output logic [31:0] pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        frame_done
);

   localparam int NWORDS = HDISP * VDISP;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [29:0] LAST = 30'(NWORDS - 1);
   localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0] ONE = (AW + 1)'(1);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] READ = 1'b1;

   logic [0:0]    state;
   logic [29:0]   word_adr;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_next;
   logic [AW:0]   count;
   logic [AW:0]   count_next;
   logic [31:0]   head_next;
   logic          push;
   logic          pop;
   logic          abort;
   logic          last_word;
   logic          stay;

   assign wshb_cyc  = (state == READ);
   assign wshb_stb  = (state == READ);
   assign wshb_we   = 1'b0;
   assign wshb_sel  = 4'b1111;
   assign wshb_bte  = 2'b00;
   assign wshb_adr  = {word_adr, 2'b00};

   assign push      = (state == READ) && wshb_ack;
   assign abort     = (state == READ) && !wshb_ack && (wshb_err || wshb_rty);
   assign pop       = pix_valid && pix_ready;
   assign last_word = (word_adr == LAST);

`ifdef WSHB_PIXEL_READER_BURST_EN
   logic full_after;
   // Burst ends on the word that fills the FIFO or closes the frame.
   assign full_after = (count == DEPTH - ONE);
   assign stay       = enable && !full_after && !last_word;
   assign wshb_cti   = (state != READ)          ? 3'b000 :
                       (full_after || last_word) ? 3'b111 : 3'b010;
`else
   assign stay     = 1'b0;
   assign wshb_cti = 3'b000;
`endif

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + ONE;
      else if (!push && pop)
         count_next = count - ONE;
   end

   // Head register: bypass the incoming word when it lands in an empty slot.
   always_comb begin
      rd_next   = pop ? rd_ptr + 1'b1 : rd_ptr;
      head_next = pix_data;
      if (push && (count == '0 || (count == ONE && pop)))
         head_next = wshb_dat_sm;
      else if (count_next != '0)
         head_next = mem[rd_next];
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= IDLE;
         word_adr   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= push && last_word;
         case (state)
            IDLE: if (enable && count < DEPTH) state <= READ;
            READ: begin
               if (push)
                  state <= stay ? READ : IDLE;
               else if (abort)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (push)
            word_adr <= last_word ? '0 : word_adr + 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (push)
         mem[wr_ptr] <= wshb_dat_sm;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         pix_valid <= 1'b0;
         pix_data  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         rd_ptr    <= rd_next;
         count     <= count_next;
         pix_valid <= (count_next != '0);
         pix_data  <= head_next;
      end
   end

endmodule

// File: doc/wshb_pixel_reader.md
WSHB_PIXEL_READER -- requirements
Module: wshb_pixel_reader

Interface
REQ-001 SHALL have parameter HDISP, default 800, pixels per line.
REQ-002 SHALL have parameter VDISP, default 480, lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, output FIFO depth in 32-bit words (power of two, >=4).
REQ-004 sys_clk  in  1  system clock (100 MHz); every register is clocked on its rising edge.
REQ-005 sys_rst  in  1  reset, asynchronous, active-high.
REQ-006 enable  in  1  when high, new bus reads may start.
REQ-007 wshb_cyc  out  1  Wishbone cycle.
REQ-008 wshb_stb  out  1  Wishbone strobe.
REQ-009 wshb_we  out  1  write enable; always 0.
REQ-010 wshb_adr  out  32  byte address.
REQ-011 wshb_sel  out  4  byte select; always 4'b1111.
REQ-012 wshb_cti  out  3  cycle type identifier.
REQ-013 wshb_bte  out  2  burst type extension; always 2'b00.
REQ-014 wshb_dat_sm  in  32  read data from slave.
REQ-015 wshb_ack, wshb_err, wshb_rty  in  1 each  slave termination.
REQ-016 pix_data  out  32  head of FIFO.
REQ-017 pix_valid  out  1  FIFO not empty.
REQ-018 pix_ready  in  1  consumer pop; pop occurs when pix_valid and pix_ready are both high.
REQ-019 frame_done  out  1  one-cycle pulse when the last frame word is accepted.

Function
REQ-020 SHALL be a read-only Wishbone master that fetches the frame buffer (HDISP*VDISP words at byte addresses 0 .. 4*(HDISP*VDISP-1)) sequentially into an internal FIFO.
REQ-021 SHALL use a two-state FSM: IDLE (cyc=stb=0) and READ (cyc=stb=1).
REQ-022 IDLE->READ SHALL occur when enable=1 and FIFO occupancy < FIFO_DEPTH; cyc/stb assert on the following cycle.
REQ-023 In READ, cyc, stb and adr SHALL stay stable until ack, err or rty is sampled high.
REQ-024 On ack: wshb_dat_sm SHALL be pushed in the same edge and adr advance by 4; FSM stays in READ if enable=1 and post-push occupancy < FIFO_DEPTH, else goes to IDLE.
REQ-025 On err or rty: no push, adr unchanged, FSM goes to IDLE and retries the same address.
REQ-026 Word address SHALL wrap from HDISP*VDISP-1 to 0 on ack; frame_done pulses high the cycle after that ack.
REQ-027 Read latency from push to pix_valid SHALL be 1 cycle (registered FIFO output flags).
REQ-028 Full FIFO: no request issued; at most one outstanding read, so overflow is impossible.
REQ-029 Empty FIFO: pix_valid=0; pix_ready ignored, no underflow.
REQ-030 Simultaneous push and pop SHALL both succeed with occupancy unchanged, including when full (pop frees the slot) and when occupancy is 1.
REQ-031 enable falling during READ SHALL NOT abort the cycle; the cycle completes, then the FSM goes to IDLE.

Reset
REQ-032 While sys_rst=1: state IDLE, cyc=stb=0, adr=0, FIFO empty, pix_valid=0, pix_data=0, frame_done=0, cti=0.
REQ-033 Reset asserted mid-cycle SHALL drop cyc/stb immediately and discard the in-flight word; after release, fetch restarts at address 0.

Configuration
REQ-034 Macro WSHB_PIXEL_READER_BURST_EN: when defined, cti=3'b010 (incrementing burst) during READ, and 3'b111 on the word where the FSM will leave READ (FIFO full after push, or frame end); when undefined, cti=3'b000 always and FSM returns to IDLE one cycle after every ack.

Verification
REQ-035 Reset, enable=1, slave acks next cycle with dat=adr, pix_ready=0 -> exactly 16 words 0x0,0x4..0x3C pushed, then cyc=0, pix_valid=1.
REQ-036 Continuous pix_ready=1, HDISP=4, VDISP=2 -> pix_data sequence 0x0..0x1C, frame_done pulse once, then 0x0 again.
REQ-037 err on address 0x8 once -> no push, cyc drops, address 0x8 re-read; output sequence has no gap or duplicate.
REQ-038 FIFO full, pix_ready pulses one cycle -> exactly one new read issued, occupancy returns to 16.
REQ-039 sys_rst pulsed while stb=1 at adr 0x20 -> cyc=0 in the same cycle, pix_valid=0, next read at address 0x0.
REQ-040 With WSHB_PIXEL_READER_BURST_EN defined -> cti=010 on reads 1..15 after reset, 111 on read 16; undefined -> cti=000 throughout.
